// File: rtl/tempo_ctrl.sv
// tempo_ctrl: button front end for the metronome beat generator.
//
// Five raw buttons are synchronised (2 flops) and debounced independently.
// Debounced rising edges become one-cycle press events. The four step
// buttons drive a small FSM that applies a single step on press, then
// auto-repeats while the same button stays held. The center button toggles
// play. Speed arithmetic saturates to [SPEED_MIN, SPEED_MAX].
//
// Ports:
//   clk        in   system clock (25 MHz)
//   rst_n      in   asynchronous active-low reset
//   left       in   raw button, step -1
//   right      in   raw button, step +1
//   down       in   raw button, step -10
//   up         in   raw button, step +10
//   center     in   raw button, toggles play
//   speed      out  current BPM, registered
//   play       out  run enable for the beat generator, registered
//   speed_upd  out  one-cycle pulse in the cycle speed takes a new value
//
// Step FSM states:
//   state     | meaning
//   ST_IDLE   | no step button owns the FSM; waiting for a press event
//   ST_DELAY  | owner held after its first step; timing the repeat delay
//   ST_REPEAT | owner still held; stepping every REPEAT_RATE cycles

module tempo_ctrl #(
  parameter int DEBOUNCE_CYC = 250000,
  parameter int REPEAT_DELAY = 12500000,
  parameter int REPEAT_RATE  = 2500000,
  parameter int SPEED_MIN    = 30,
  parameter int SPEED_MAX    = 240,
  parameter int SPEED_INIT   = 60
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       left,
  input  logic       right,
  input  logic       down,
  input  logic       up,
  input  logic       center,
  output logic [7:0] speed,
  output logic       play,
  output logic       speed_upd
);

  localparam int NB      = 5;
  localparam int DB_W    = (DEBOUNCE_CYC > 2) ? $clog2(DEBOUNCE_CYC) : 1;
  localparam int TMR_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int TMR_W   = (TMR_MAX > 2) ? $clog2(TMR_MAX) : 1;

  localparam logic [DB_W-1:0]  DB_LAST    = DB_W'(DEBOUNCE_CYC - 1);
  localparam logic [TMR_W-1:0] DELAY_LOAD = TMR_W'(REPEAT_DELAY - 1);
  localparam logic [TMR_W-1:0] RATE_LOAD  = TMR_W'(REPEAT_RATE - 1);

  localparam logic [7:0]        SPEED_MIN_V  = 8'(SPEED_MIN);
  localparam logic [7:0]        SPEED_MAX_V  = 8'(SPEED_MAX);
  localparam logic [7:0]        SPEED_INIT_V = 8'(SPEED_INIT);
  localparam logic signed [9:0] MIN_S        = 10'(SPEED_MIN);
  localparam logic signed [9:0] MAX_S        = 10'(SPEED_MAX);

  // Button bit positions; the step buttons occupy [3:0] in priority order.
  localparam int B_LEFT   = 0;
  localparam int B_RIGHT  = 1;
  localparam int B_DOWN   = 2;
  localparam int B_CENTER = 4;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DELAY  = 2'd1,
    ST_REPEAT = 2'd2
  } state_t;

  logic [NB-1:0] raw;
  logic [NB-1:0] sync1_q, sync1_d;
  logic [NB-1:0] sync2_q, sync2_d;
  logic [NB-1:0] deb_q, deb_d;
  logic [NB-1:0] deb_prev_q, deb_prev_d;
  logic [NB-1:0][DB_W-1:0] db_cnt_q, db_cnt_d;
  logic [NB-1:0] press;

  state_t            state_q, state_d;
  logic [1:0]        owner_q, owner_d;
  logic [TMR_W-1:0]  timer_q, timer_d;
  logic [3:0]        step_lvl;
  logic              step_en;
  logic [1:0]        step_sel;

  logic signed [9:0] step_val;
  logic signed [9:0] sum;
  logic [7:0]        clamp;

  logic [7:0] speed_q, speed_d;
  logic       play_q, play_d;
  logic       speed_upd_q, speed_upd_d;

  assign raw = {center, up, down, right, left};

  // Synchroniser and debouncers.
  always_comb begin
    sync1_d    = raw;
    sync2_d    = sync1_q;
    deb_prev_d = deb_q;
    deb_d      = deb_q;
    db_cnt_d   = '0;
    for (int i = 0; i < NB; i++) begin
      if (sync2_q[i] != deb_q[i]) begin
        if (db_cnt_q[i] == DB_LAST) begin
          deb_d[i] = ~deb_q[i];
        end else begin
          db_cnt_d[i] = db_cnt_q[i] + 1'b1;
        end
      end
    end
  end

  assign press    = deb_q & ~deb_prev_q;
  assign step_lvl = deb_q[3:0];

  // Step FSM. The timer counts down from (interval - 1); a step fires at zero,
  // which lands exactly REPEAT_DELAY / REPEAT_RATE cycles after the prior step.
  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    timer_d  = timer_q;
    step_en  = 1'b0;
    step_sel = owner_q;
    case (state_q)
      ST_IDLE: begin
        if (|press[3:0]) begin
          if (press[B_LEFT])       step_sel = 2'd0;
          else if (press[B_RIGHT]) step_sel = 2'd1;
          else if (press[B_DOWN])  step_sel = 2'd2;
          else                     step_sel = 2'd3;
          owner_d = step_sel;
          step_en = 1'b1;
          timer_d = DELAY_LOAD;
          state_d = ST_DELAY;
        end
      end
      ST_DELAY: begin
        // Release is checked first so a release never coincides with a step.
        if (!step_lvl[owner_q]) begin
          state_d = ST_IDLE;
        end else if (timer_q == '0) begin
          step_en = 1'b1;
          timer_d = RATE_LOAD;
          state_d = ST_REPEAT;
        end else begin
          timer_d = timer_q - 1'b1;
        end
      end
      ST_REPEAT: begin
        if (!step_lvl[owner_q]) begin
          state_d = ST_IDLE;
        end else if (timer_q == '0) begin
          step_en = 1'b1;
          timer_d = RATE_LOAD;
        end else begin
          timer_d = timer_q - 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Saturating speed arithmetic, done wide and signed so it cannot wrap.
  always_comb begin
    case (step_sel)
      2'd0:    step_val = -10'sd1;
      2'd1:    step_val = 10'sd1;
      2'd2:    step_val = -10'sd10;
      default: step_val = 10'sd10;
    endcase
    sum = $signed({2'b00, speed_q}) + step_val;
    if (sum < MIN_S) begin
      clamp = SPEED_MIN_V;
    end else if (sum > MAX_S) begin
      clamp = SPEED_MAX_V;
    end else begin
      clamp = sum[7:0];
    end
  end

  always_comb begin
    speed_d     = speed_q;
    speed_upd_d = 1'b0;
    play_d      = play_q ^ press[B_CENTER];
    if (step_en) begin
      speed_d     = clamp;
      speed_upd_d = (clamp != speed_q);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q     <= '0;
      sync2_q     <= '0;
      deb_q       <= '0;
      deb_prev_q  <= '0;
      db_cnt_q    <= '0;
      state_q     <= ST_IDLE;
      owner_q     <= '0;
      timer_q     <= '0;
      speed_q     <= SPEED_INIT_V;
      play_q      <= 1'b0;
      speed_upd_q <= 1'b0;
    end else begin
      sync1_q     <= sync1_d;
      sync2_q     <= sync2_d;
      deb_q       <= deb_d;
      deb_prev_q  <= deb_prev_d;
      db_cnt_q    <= db_cnt_d;
      state_q     <= state_d;
      owner_q     <= owner_d;
      timer_q     <= timer_d;
      speed_q     <= speed_d;
      play_q      <= play_d;
      speed_upd_q <= speed_upd_d;
    end
  end

  assign speed     = speed_q;
  assign play      = play_q;
  assign speed_upd = speed_upd_q;

endmodule
